// File: rtl/qsn_shift_scheduler_if.sv
// Block stream between the message-memory read path, the QSN scheduler and the check-node units.
// The scheduler connects through the slave modport, and its environment connects through master.
interface qsn_shift_scheduler_if #(
  parameter int unsigned LIFTING_FACTOR = 4,
  parameter int unsigned SHIFT_WIDTH    = 2,
  parameter int unsigned IDX_WIDTH      = 3
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LIFTING_FACTOR-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [LIFTING_FACTOR-1:0] out_data;
  logic [SHIFT_WIDTH-1:0]    out_shift;
  logic [IDX_WIDTH-1:0]      out_idx;
  logic                      out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_shift, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_shift, out_idx, out_last
  );
endinterface

// File: rtl/qsn_shift_scheduler.sv
// Quasi-cyclic shift scheduler. It rotates each Z-bit block by the programmed circulant shift
// and walks the shift table for num_iter passes, using a registered valid/ready output.
module qsn_shift_scheduler #(
  parameter int unsigned LIFTING_FACTOR = 4,
  parameter int unsigned SHIFT_WIDTH    = 2,
  parameter int unsigned TABLE_DEPTH    = 8,
  parameter int unsigned IDX_WIDTH      = 3,
  parameter int unsigned ITER_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [IDX_WIDTH-1:0]   cfg_addr,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic [IDX_WIDTH:0]     cfg_len,
  input  logic [ITER_WIDTH-1:0]  num_iter,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  qsn_shift_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  localparam logic [IDX_WIDTH:0]    MaxLen  = (IDX_WIDTH+1)'(TABLE_DEPTH);
  localparam logic [IDX_WIDTH:0]    LenOne  = (IDX_WIDTH+1)'(1);
  localparam logic [IDX_WIDTH-1:0]  IdxOne  = IDX_WIDTH'(1);
  localparam logic [ITER_WIDTH-1:0] IterOne = ITER_WIDTH'(1);

  state_e                    state_q, state_d;
  logic [SHIFT_WIDTH-1:0]    shift_tab_q [TABLE_DEPTH];
  logic [IDX_WIDTH:0]        len_q, len_d;
  logic [ITER_WIDTH-1:0]     iter_max_q, iter_max_d;
  logic [IDX_WIDTH-1:0]      idx_q, idx_d;
  logic [ITER_WIDTH-1:0]     iter_q, iter_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      out_valid_q, out_valid_d;
  logic [LIFTING_FACTOR-1:0] out_data_q, out_data_d;
  logic [SHIFT_WIDTH-1:0]    out_shift_q, out_shift_d;
  logic [IDX_WIDTH-1:0]      out_idx_q, out_idx_d;
  logic                      out_last_q, out_last_d;

  logic                      in_ready;
  logic                      xfer;
  logic                      cfg_ok;
  logic                      idx_end;
  logic                      iter_end;
  logic [IDX_WIDTH:0]        len_clamped;
  logic [SHIFT_WIDTH-1:0]    cur_shift;
  logic [SHIFT_WIDTH-1:0]    sel;
  logic [LIFTING_FACTOR-1:0] rot;

  assign cur_shift   = shift_tab_q[idx_q];
  assign cfg_ok      = (cfg_len != '0) && (num_iter != '0);
  assign len_clamped = (cfg_len > MaxLen) ? MaxLen : cfg_len;
  assign idx_end     = ({1'b0, idx_q} == (len_q - LenOne));
  assign iter_end    = (iter_q == (iter_max_q - IterOne));

  // Z is a power of two, so the SHIFT_WIDTH-bit sum wraps exactly mod Z.
  always_comb begin
    rot = '0;
    sel = '0;
    for (int i = 0; i < int'(LIFTING_FACTOR); i++) begin
      sel    = SHIFT_WIDTH'(i) + cur_shift;
      rot[i] = bus.in_data[sel];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && cfg_ok) state_d = StRun;
      StRun:   if (xfer && idx_end && iter_end) state_d = StFlush;
      StFlush: if (out_valid_q && bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (state_q == StRun) && (!out_valid_q || bus.out_ready);
    xfer     = bus.in_valid && in_ready;
  end

  always_comb begin
    len_d       = len_q;
    iter_max_d  = iter_max_q;
    idx_d       = idx_q;
    iter_d      = iter_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_shift_d = out_shift_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_ok) begin
            len_d      = len_clamped;
            iter_max_d = num_iter;
            idx_d      = '0;
            iter_d     = '0;
            busy_d     = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (xfer) begin
          // A new block overwrites the one being handed off in the same cycle.
          out_valid_d = 1'b1;
          out_data_d  = rot;
          out_shift_d = cur_shift;
          out_idx_d   = idx_q;
          out_last_d  = idx_end && iter_end;
          if (idx_end) begin
            idx_d  = '0;
            iter_d = iter_q + IterOne;
          end else begin
            idx_d = idx_q + IdxOne;
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      StFlush: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TABLE_DEPTH); i++) begin
        shift_tab_q[i] <= '0;
      end
      len_q       <= '0;
      iter_max_q  <= '0;
      idx_q       <= '0;
      iter_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_shift_q <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (cfg_we && (state_q == StIdle)) begin
        shift_tab_q[cfg_addr] <= cfg_shift;
      end
      len_q       <= len_d;
      iter_max_q  <= iter_max_d;
      idx_q       <= idx_d;
      iter_q      <= iter_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_shift_q <= out_shift_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_shift = out_shift_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_qsn_shift_scheduler.sv
// Directed bench for qsn_shift_scheduler. It covers rotation, multi-pass runs, backpressure,
// empty runs, table writes during a run, and a reset in the middle of a run.
module tb_qsn_shift_scheduler;
  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [1:0] cfg_shift;
  logic [3:0] cfg_len;
  logic [3:0] num_iter;
  logic       start;
  logic       busy;
  logic       done;

  int n_pass;
  int n_total;

  qsn_shift_scheduler_if #(.LIFTING_FACTOR(4), .SHIFT_WIDTH(2), .IDX_WIDTH(3)) bus ();

  qsn_shift_scheduler #(
    .LIFTING_FACTOR(4),
    .SHIFT_WIDTH   (2),
    .TABLE_DEPTH   (8),
    .IDX_WIDTH     (3),
    .ITER_WIDTH    (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_shift(cfg_shift),
    .cfg_len  (cfg_len),
    .num_iter (num_iter),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [1:0] val);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_shift = val;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic go(input logic [3:0] len, input logic [3:0] iter);
    cfg_len  = len;
    num_iter = iter;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  logic [3:0] exp1 [4];
  logic [3:0] vec6 [4];

  initial begin
    n_pass = 0;
    n_total = 0;
    exp1 = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};
    vec6 = '{4'b0011, 4'b0110, 4'b1100, 4'b1010};
    rst_n = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_shift = '0; cfg_len = '0; num_iter = '0; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_shift", bus.out_shift, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_last", bus.out_last, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Run 1: table {0,1,2,3}, one pass of four blocks
    wr(0, 0); wr(1, 1); wr(2, 2); wr(3, 3);
    go(4, 1);
    chk("t1_busy", busy, 1);
    chk("t1_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_data = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_valid", bus.out_valid, 1);
      chk("t1_data", bus.out_data, exp1[k]);
      chk("t1_idx", bus.out_idx, k);
      chk("t1_last", bus.out_last, (k == 3) ? 1 : 0);
    end
    bus.in_valid = 1'b0;
    #1 chk("t1_flush_in_ready", bus.in_ready, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_busy_clr", busy, 0);
    chk("t1_valid_clr", bus.out_valid, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // Run 2: table[0]=1, one entry, three passes
    wr(0, 1);
    go(1, 3);
    bus.in_valid = 1'b1; bus.in_data = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_data", bus.out_data, 4'b1001);
      chk("t2_idx", bus.out_idx, 0);
      chk("t2_last", bus.out_last, (k == 2) ? 1 : 0);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("t2_done", done, 1);

    // Table writes while running must be ignored
    tick();
    go(1, 1);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_shift = 2'd3;
    bus.in_valid = 1'b1; bus.in_data = 4'b0011;
    tick();
    cfg_we = 1'b0; bus.in_valid = 1'b0;
    chk("t5_data", bus.out_data, 4'b1001);
    chk("t5_shift", bus.out_shift, 1);
    tick();
    chk("t5_done", done, 1);
    go(1, 1);
    bus.in_valid = 1'b1; bus.in_data = 4'b0001;
    tick();
    bus.in_valid = 1'b0;
    chk("t5_keep_data", bus.out_data, 4'b1000);
    chk("t5_keep_shift", bus.out_shift, 1);
    tick();
    chk("t5_keep_done", done, 1);

    // Backpressure: hold the first block for five cycles
    wr(0, 0);
    go(4, 1);
    bus.in_valid = 1'b1; bus.in_data = 4'b0001;
    tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_in_ready", bus.in_ready, 0);
      chk("t3_hold_valid", bus.out_valid, 1);
      chk("t3_hold_data", bus.out_data, 4'b0001);
      chk("t3_hold_idx", bus.out_idx, 0);
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("t3_data", bus.out_data, exp1[k]);
      chk("t3_idx", bus.out_idx, k);
    end
    bus.in_valid = 1'b0;
    chk("t3_last", bus.out_last, 1);
    tick();
    chk("t3_done", done, 1);

    // Empty runs: zero length and zero iterations
    tick();
    go(0, 5);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_in_ready", bus.in_ready, 0);
    tick();
    chk("t4_done_pulse", done, 0);
    chk("t4_busy2", busy, 0);
    go(2, 0);
    chk("t4_iter0_done", done, 1);
    chk("t4_iter0_busy", busy, 0);

    // Reset after two blocks of a four-block run
    wr(1, 3);
    go(4, 1);
    bus.in_valid = 1'b1; bus.in_data = 4'b0001;
    tick();
    tick();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_out_data", bus.out_data, 0);
    chk("t6_out_idx", bus.out_idx, 0);
    chk("t6_in_ready", bus.in_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_no_done", done, 0);
    go(4, 1);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_data = vec6[k];
      tick();
      chk("t6_plain_data", bus.out_data, vec6[k]);
      chk("t6_plain_shift", bus.out_shift, 0);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("t6_done2", done, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
